// File: rtl/nv_ram_rwsp_16x65_fifo_ctrl_pkg.sv
// Shared constants for the 16x65 two-port RAM FIFO controller and its output buffer.
package nv_ram_rwsp_16x65_fifo_ctrl_pkg;

  localparam int unsigned DEPTH      = 16;
  localparam int unsigned AW         = 4;
  localparam int unsigned DW         = 65;
  localparam int unsigned RD_LAT     = 2;
  localparam int unsigned OBUF_DEPTH = 3;

  localparam int unsigned CNT_W   = AW + 2;
  localparam int unsigned OBUF_CW = $clog2(OBUF_DEPTH + 1);
  // Reads in flight plus buffered words; wide enough for the transient sum.
  localparam int unsigned OCC_W   = $clog2(OBUF_DEPTH + RD_LAT + 1);

endpackage

// File: rtl/nv_fifo_ctrl_obuf.sv
// Small flop FIFO used as the output skid buffer behind a RAM read pipeline.
module nv_fifo_ctrl_obuf
  import nv_ram_rwsp_16x65_fifo_ctrl_pkg::*;
#(
  parameter int unsigned Depth = OBUF_DEPTH,
  parameter int unsigned Width = DW,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic [CntW-1:0]  cnt_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Width-1:0] mem_q [Depth];

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q + CntW'(push_i) - CntW'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o = mem_q[rd_ptr_q];
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/nv_ram_rwsp_16x65_fifo_ctrl.sv
// FIFO controller driving an external 16x65 two-port RAM with a two-stage read
// (address register, output register) and a credit-managed output skid buffer.
module nv_ram_rwsp_16x65_fifo_ctrl
  import nv_ram_rwsp_16x65_fifo_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [DW-1:0]    wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [DW-1:0]    rd_pd,
  output logic             ram_we,
  output logic [AW-1:0]    ram_wa,
  output logic [DW-1:0]    ram_di,
  output logic             ram_re,
  output logic [AW-1:0]    ram_ra,
  output logic             ram_ore,
  input  logic [DW-1:0]    ram_dout,
  output logic [CNT_W-1:0] fifo_cnt,
  output logic             idle
);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       ram_cnt_q, ram_cnt_d;
  logic [RD_LAT-1:0] rv_q, rv_d;
  logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;

  logic [OBUF_CW-1:0] obuf_cnt;
  logic [DW-1:0]      obuf_data;
  logic [OCC_W-1:0]   occ;
  logic               wr_acc;
  logic               rd_issue;
  logic               credit_ok;
  logic               obuf_push;
  logic               obuf_pop;

  // Every issued read owns an obuf slot until it is popped.
  always_comb begin
    occ = OCC_W'(obuf_cnt);
    for (int i = 0; i < RD_LAT; i++) begin
      occ = occ + OCC_W'(rv_q[i]);
    end
  end

  always_comb begin
    wr_prdy   = ~rst & (ram_cnt_q < (AW + 1)'(DEPTH));
    wr_acc    = wr_pvld & wr_prdy;
    rd_pvld   = ~rst & (obuf_cnt != '0);
    obuf_pop  = rd_pvld & rd_prdy;
    credit_ok = (occ < OCC_W'(OBUF_DEPTH)) | ((occ == OCC_W'(OBUF_DEPTH)) & obuf_pop);
    rd_issue  = ~rst & (ram_cnt_q != '0) & credit_ok;
    obuf_push = ~rst & rv_q[RD_LAT-1];

    ram_we  = wr_acc;
    ram_wa  = wr_ptr_q;
    ram_di  = wr_pd;
    ram_re  = rd_issue;
    ram_ra  = rd_ptr_q;
    ram_ore = ~rst & rv_q[0];
    rd_pd   = obuf_data;

    fifo_cnt = fifo_cnt_q;
    idle     = rst | (fifo_cnt_q == '0);
  end

  always_comb begin
    wr_ptr_d   = wr_acc   ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = rd_issue ? rd_ptr_q + AW'(1) : rd_ptr_q;
    rv_d       = {rv_q[RD_LAT-2:0], rd_issue};
    fifo_cnt_d = fifo_cnt_q + CNT_W'(wr_acc) - CNT_W'(obuf_pop);
    ram_cnt_d  = ram_cnt_q;
    unique case ({wr_acc, rd_issue})
      2'b10:   ram_cnt_d = ram_cnt_q + (AW + 1)'(1);
      2'b01:   ram_cnt_d = ram_cnt_q - (AW + 1)'(1);
      default: ram_cnt_d = ram_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      rv_q       <= '0;
      fifo_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      rv_q       <= rv_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  nv_fifo_ctrl_obuf #(
    .Depth (OBUF_DEPTH),
    .Width (DW),
    .CntW  (OBUF_CW)
  ) u_obuf (
    .clk_i  (clk),
    .rst_i  (rst),
    .push_i (obuf_push),
    .data_i (ram_dout),
    .pop_i  (obuf_pop),
    .data_o (obuf_data),
    .cnt_o  (obuf_cnt)
  );

endmodule

// File: tb/tb_nv_ram_rwsp_16x65_fifo_ctrl.sv
// Directed and randomized checks of the RAM FIFO controller against a RAM model.
module tb_nv_ram_rwsp_16x65_fifo_ctrl;
  import nv_ram_rwsp_16x65_fifo_ctrl_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_pvld;
  logic             wr_prdy;
  logic [DW-1:0]    wr_pd;
  logic             rd_pvld;
  logic             rd_prdy;
  logic [DW-1:0]    rd_pd;
  logic             ram_we;
  logic [AW-1:0]    ram_wa;
  logic [DW-1:0]    ram_di;
  logic             ram_re;
  logic [AW-1:0]    ram_ra;
  logic             ram_ore;
  logic [DW-1:0]    ram_dout;
  logic [CNT_W-1:0] fifo_cnt;
  logic             idle;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // RAM model: read address captured on ram_re, output register loaded on ram_ore.
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ra_q;
  logic [DW-1:0] dout_q;
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ra_q <= ram_ra;
    if (ram_ore) dout_q <= mem[ra_q];
  end
  assign ram_dout = dout_q;

  nv_ram_rwsp_16x65_fifo_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .wr_pvld  (wr_pvld),
    .wr_prdy  (wr_prdy),
    .wr_pd    (wr_pd),
    .rd_pvld  (rd_pvld),
    .rd_prdy  (rd_prdy),
    .rd_pd    (rd_pd),
    .ram_we   (ram_we),
    .ram_wa   (ram_wa),
    .ram_di   (ram_di),
    .ram_re   (ram_re),
    .ram_ra   (ram_ra),
    .ram_ore  (ram_ore),
    .ram_dout (ram_dout),
    .fifo_cnt (fifo_cnt),
    .idle     (idle)
  );

  function automatic logic [DW-1:0] mk(input int i);
    logic [31:0] u;
    u = i;
    return {u[0], u ^ 32'hA5A5_0000, u * 32'd3 + 32'd7};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_pvld = 1'b1; wr_pd = mk(99); rd_prdy = 1'b1;
    tick();
    tick();
    #1;
    checks++; if (wr_prdy !== 1'b0) begin errors++; $display("FAIL rst_wr_prdy got %0b exp 0", wr_prdy); end
    checks++; if (rd_pvld !== 1'b0) begin errors++; $display("FAIL rst_rd_pvld got %0b exp 0", rd_pvld); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we got %0b exp 0", ram_we); end
    checks++; if (ram_re !== 1'b0) begin errors++; $display("FAIL rst_ram_re got %0b exp 0", ram_re); end
    checks++; if (ram_ore !== 1'b0) begin errors++; $display("FAIL rst_ram_ore got %0b exp 0", ram_ore); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle got %0b exp 1", idle); end
    rst = 1'b0; wr_pvld = 1'b0;
    #1;
    checks++; if (wr_prdy !== 1'b1) begin errors++; $display("FAIL post_rst_wr_prdy got %0b exp 1", wr_prdy); end
    checks++; if (fifo_cnt !== 6'd0) begin errors++; $display("FAIL post_rst_fifo_cnt got %0d exp 0", fifo_cnt); end
    checks++; if (rd_pvld !== 1'b0) begin errors++; $display("FAIL post_rst_rd_pvld got %0b exp 0", rd_pvld); end
    tick();
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    d = 65'h1_2345_6789_ABCD_EF01;
    wr_pvld = 1'b1; wr_pd = d; rd_prdy = 1'b1;
    #1;
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL single_we got %0b exp 1", ram_we); end
    checks++; if (ram_wa !== 4'd0) begin errors++; $display("FAIL single_wa got %0d exp 0", ram_wa); end
    checks++; if (ram_di !== d) begin errors++; $display("FAIL single_di got %h exp %h", ram_di, d); end
    tick();
    wr_pvld = 1'b0;
    #1;
    checks++; if (ram_re !== 1'b1) begin errors++; $display("FAIL single_re_c1 got %0b exp 1", ram_re); end
    checks++; if (ram_ra !== 4'd0) begin errors++; $display("FAIL single_ra_c1 got %0d exp 0", ram_ra); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL single_we_c1 got %0b exp 0", ram_we); end
    tick(); #1;
    checks++; if (ram_ore !== 1'b1) begin errors++; $display("FAIL single_ore_c2 got %0b exp 1", ram_ore); end
    checks++; if (ram_re !== 1'b0) begin errors++; $display("FAIL single_re_c2 got %0b exp 0", ram_re); end
    tick(); #1;
    checks++; if (rd_pvld !== 1'b0) begin errors++; $display("FAIL single_pvld_c3 got %0b exp 0", rd_pvld); end
    tick(); #1;
    checks++; if (rd_pvld !== 1'b1) begin errors++; $display("FAIL single_pvld_c4 got %0b exp 1", rd_pvld); end
    checks++; if (rd_pd !== d) begin errors++; $display("FAIL single_pd_c4 got %h exp %h", rd_pd, d); end
    checks++; if (fifo_cnt !== 6'd1) begin errors++; $display("FAIL single_cnt_c4 got %0d exp 1", fifo_cnt); end
    tick(); #1;
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle_c5 got %0b exp 1", idle); end
    checks++; if (rd_pvld !== 1'b0) begin errors++; $display("FAIL single_pvld_c5 got %0b exp 0", rd_pvld); end
    tick();
  endtask

  task automatic test_stream();
    int wi = 0, ri = 0, first = -1, last = -1, gaps = 0;
    rd_prdy = 1'b1;
    for (int c = 0; c < 100 && ri < 64; c++) begin
      wr_pvld = (wi < 64); wr_pd = mk(1000 + wi);
      #1;
      if (wi < 64) begin
        checks++; if (wr_prdy !== 1'b1) begin errors++; $display("FAIL stream_wr_prdy c=%0d got %0b exp 1", c, wr_prdy); end
      end
      if (rd_pvld) begin
        checks++;
        if (rd_pd !== mk(1000 + ri)) begin errors++; $display("FAIL stream_data idx=%0d got %h exp %h", ri, rd_pd, mk(1000 + ri)); end
        if (first < 0) first = c;
        last = c; ri++;
      end else if (first >= 0) gaps++;
      if (wr_pvld && wr_prdy) wi++;
      tick();
    end
    wr_pvld = 1'b0;
    checks++; if (ri != 64) begin errors++; $display("FAIL stream_count got %0d exp 64", ri); end
    checks++; if (first != 4) begin errors++; $display("FAIL stream_first got %0d exp 4", first); end
    checks++; if (last != 67) begin errors++; $display("FAIL stream_last got %0d exp 67", last); end
    checks++; if (gaps != 0) begin errors++; $display("FAIL stream_gaps got %0d exp 0", gaps); end
    tick(); tick();
  endtask

  task automatic test_full();
    int wi = 0, ri = 0;
    rd_prdy = 1'b0;
    for (int c = 0; c < 40; c++) begin
      wr_pvld = 1'b1; wr_pd = mk(2000 + wi);
      #1;
      if (!wr_prdy) break;
      wi++;
      tick();
    end
    checks++; if (wi != 19) begin errors++; $display("FAIL full_accepted got %0d exp 19", wi); end
    for (int c = 0; c < 3; c++) begin
      tick(); #1;
      checks++; if (wr_prdy !== 1'b0) begin errors++; $display("FAIL full_wr_prdy_hold got %0b exp 0", wr_prdy); end
    end
    checks++; if (fifo_cnt !== 6'd19) begin errors++; $display("FAIL full_fifo_cnt got %0d exp 19", fifo_cnt); end
    tick();
    // Release the reader while a write is pending against the full RAM.
    rd_prdy = 1'b1; wr_pvld = 1'b1; wr_pd = mk(2000 + 19);
    #1;
    checks++; if (ram_re !== 1'b1) begin errors++; $display("FAIL full_issue got %0b exp 1", ram_re); end
    checks++; if (wr_prdy !== 1'b0) begin errors++; $display("FAIL full_collide_prdy got %0b exp 0", wr_prdy); end
    checks++; if (rd_pd !== mk(2000)) begin errors++; $display("FAIL full_head got %h exp %h", rd_pd, mk(2000)); end
    if (rd_pvld) ri++;
    tick(); #1;
    checks++; if (wr_prdy !== 1'b1) begin errors++; $display("FAIL full_prdy_after got %0b exp 1", wr_prdy); end
    if (rd_pvld) begin
      checks++; if (rd_pd !== mk(2000 + ri)) begin errors++; $display("FAIL full_data idx=%0d got %h exp %h", ri, rd_pd, mk(2000 + ri)); end
      ri++;
    end
    tick();
    wr_pvld = 1'b0;
    for (int c = 0; c < 60 && ri < 20; c++) begin
      #1;
      if (rd_pvld) begin
        checks++; if (rd_pd !== mk(2000 + ri)) begin errors++; $display("FAIL full_data idx=%0d got %h exp %h", ri, rd_pd, mk(2000 + ri)); end
        ri++;
      end
      tick();
    end
    checks++; if (ri != 20) begin errors++; $display("FAIL full_drain_count got %0d exp 20", ri); end
    tick(); tick(); #1;
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL full_idle got %0b exp 1", idle); end
    checks++; if (rd_pvld !== 1'b0) begin errors++; $display("FAIL full_extra_pvld got %0b exp 0", rd_pvld); end
    tick();
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] e;
    int wi = 0, ri = 0, mram = 0, oc = 0;
    logic prev_re = 1'b0;
    for (int c = 0; c < 20000 && ri < 2000; c++) begin
      wr_pvld = (wi < 2000) && ($urandom_range(0, 1) == 1);
      wr_pd   = mk(5000 + wi);
      rd_prdy = ($urandom_range(0, 1) == 1);
      #1;
      checks++; if (wr_prdy !== (mram < 16)) begin errors++; $display("FAIL rand_wr_prdy c=%0d got %0b ram_cnt %0d", c, wr_prdy, mram); end
      checks++; if (ram_ore !== prev_re) begin errors++; $display("FAIL rand_ore c=%0d got %0b exp %0b", c, ram_ore, prev_re); end
      checks++; if (int'(fifo_cnt) != exp_q.size()) begin errors++; $display("FAIL rand_fifo_cnt c=%0d got %0d exp %0d", c, fifo_cnt, exp_q.size()); end
      if (ram_re) begin
        checks++; if (mram == 0) begin errors++; $display("FAIL rand_issue_empty c=%0d got re=1 exp 0", c); end
      end
      if (rd_pvld && rd_prdy) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rand_pop_empty c=%0d got %h exp none", c, rd_pd); end
        else begin
          e = exp_q.pop_front();
          if (rd_pd !== e) begin errors++; $display("FAIL rand_data idx=%0d got %h exp %h", ri, rd_pd, e); end
        end
        ri++; oc--;
      end
      if (wr_pvld && wr_prdy) begin exp_q.push_back(wr_pd); wi++; mram++; end
      if (ram_re) begin mram--; oc++; end
      checks++; if (oc > 3) begin errors++; $display("FAIL rand_obuf_occ c=%0d got %0d exp <=3", c, oc); end
      prev_re = ram_re;
      tick();
    end
    wr_pvld = 1'b0; rd_prdy = 1'b0;
    checks++; if (ri != 2000) begin errors++; $display("FAIL rand_count got %0d exp 2000", ri); end
    tick();
  endtask

  task automatic test_reset_midop();
    int pops = 0;
    rd_prdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_pvld = 1'b1; wr_pd = mk(7000 + i);
      tick();
    end
    wr_pvld = 1'b0;
    tick(); tick(); tick();
    rd_prdy = 1'b1;
    tick(); tick();
    // Two reads are now in flight.
    rd_prdy = 1'b0; rst = 1'b1;
    #1;
    checks++; if (ram_ore !== 1'b0) begin errors++; $display("FAIL mid_rst_ore got %0b exp 0", ram_ore); end
    checks++; if (rd_pvld !== 1'b0) begin errors++; $display("FAIL mid_rst_pvld got %0b exp 0", rd_pvld); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (rd_pvld !== 1'b0) begin errors++; $display("FAIL mid_after_pvld got %0b exp 0", rd_pvld); end
    checks++; if (fifo_cnt !== 6'd0) begin errors++; $display("FAIL mid_after_cnt got %0d exp 0", fifo_cnt); end
    checks++; if (wr_prdy !== 1'b1) begin errors++; $display("FAIL mid_after_prdy got %0b exp 1", wr_prdy); end
    wr_pvld = 1'b1; wr_pd = 65'h0AA; rd_prdy = 1'b1;
    #1;
    checks++; if (ram_wa !== 4'd0) begin errors++; $display("FAIL mid_wa got %0d exp 0", ram_wa); end
    tick();
    wr_pvld = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      #1;
      if (c == 1) begin
        checks++; if (ram_re !== 1'b1 || ram_ra !== 4'd0) begin errors++; $display("FAIL mid_issue got re=%0b ra=%0d exp re=1 ra=0", ram_re, ram_ra); end
      end
      if (rd_pvld) begin
        pops++;
        checks++; if (c != 4 || rd_pd !== 65'h0AA) begin errors++; $display("FAIL mid_pop got cycle %0d data %h exp cycle 4 data 0aa", c, rd_pd); end
      end
      tick();
    end
    checks++; if (pops != 1) begin errors++; $display("FAIL mid_pop_count got %0d exp 1", pops); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_pvld = 1'b0; wr_pd = '0; rd_prdy = 1'b0;
    test_reset();
    test_single();
    test_stream();
    test_full();
    test_random();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
